// File: rtl/color_sequence_display.sv
// Colour LED sequencer: shows each accepted colour for ON_CYCLES, then a dark gap of OFF_CYCLES, then pulses show_done.
// Optional buzzer tone output enabled by defining COLOR_DISPLAY_TONE_EN.
module color_sequence_display #(
  parameter int unsigned ON_CYCLES     = 25_000_000,
  parameter int unsigned OFF_CYCLES    = 12_500_000
`ifdef COLOR_DISPLAY_TONE_EN
  , parameter int unsigned TONE_DIV_BASE = 25_000
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] color_in,
  input  logic       color_valid,
  output logic       color_ready,
  input  logic       flush,
  output logic       led_green,
  output logic       led_red,
  output logic       led_blue,
  output logic       led_yellow,
  output logic       busy,
  output logic       show_done
`ifdef COLOR_DISPLAY_TONE_EN
  , output logic     tone_out
`endif
);

  localparam int unsigned MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {IDLE, ON, GAP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       color_q, color_nxt;
  logic [3:0]       leds_q, leds_nxt;
  logic             done_q, done_nxt;
  logic             hs;

`ifdef COLOR_DISPLAY_TONE_EN
  localparam int unsigned TONE_W = $clog2(TONE_DIV_BASE * 4);
  localparam logic [TONE_W-1:0] HALF0 = TONE_W'(TONE_DIV_BASE * 1 - 1);
  localparam logic [TONE_W-1:0] HALF1 = TONE_W'(TONE_DIV_BASE * 2 - 1);
  localparam logic [TONE_W-1:0] HALF2 = TONE_W'(TONE_DIV_BASE * 3 - 1);
  localparam logic [TONE_W-1:0] HALF3 = TONE_W'(TONE_DIV_BASE * 4 - 1);

  logic [TONE_W-1:0] tone_cnt, tone_cnt_nxt, tone_half_m1;
  logic              tone_q, tone_nxt;

  // Lower colour code -> shorter half-period -> higher pitch.
  always_comb begin
    tone_half_m1 = HALF0;
    case (color_q)
      2'd0:    tone_half_m1 = HALF0;
      2'd1:    tone_half_m1 = HALF1;
      2'd2:    tone_half_m1 = HALF2;
      default: tone_half_m1 = HALF3;
    endcase
  end

  assign tone_out = tone_q;
`endif

  function automatic logic [3:0] onehot(input logic [1:0] c);
    return 4'(1) << c;
  endfunction

  assign color_ready = (state == IDLE) && !flush;
  assign hs          = color_valid && color_ready;
  assign busy        = (state != IDLE);
  assign led_green   = leds_q[0];
  assign led_red     = leds_q[1];
  assign led_blue    = leds_q[2];
  assign led_yellow  = leds_q[3];
  assign show_done   = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      color_q  <= '0;
      leds_q   <= '0;
      done_q   <= 1'b0;
`ifdef COLOR_DISPLAY_TONE_EN
      tone_cnt <= '0;
      tone_q   <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      color_q  <= color_nxt;
      leds_q   <= leds_nxt;
      done_q   <= done_nxt;
`ifdef COLOR_DISPLAY_TONE_EN
      tone_cnt <= tone_cnt_nxt;
      tone_q   <= tone_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    color_nxt    = color_q;
    leds_nxt     = leds_q;
    done_nxt     = 1'b0;
`ifdef COLOR_DISPLAY_TONE_EN
    tone_cnt_nxt = tone_cnt;
    tone_nxt     = 1'b0;
`endif
    case (state)
      IDLE: begin
        leds_nxt = '0;
        if (hs) begin
          state_nxt = ON;
          cnt_nxt   = CNT_W'(ON_CYCLES - 1);
          color_nxt = color_in;
          leds_nxt  = onehot(color_in);
`ifdef COLOR_DISPLAY_TONE_EN
          tone_cnt_nxt = '0;
`endif
        end
      end
      ON: begin
        if (cnt == '0) begin
          state_nxt = GAP;
          cnt_nxt   = CNT_W'(OFF_CYCLES - 1);
          leds_nxt  = '0;
        end else begin
          cnt_nxt  = cnt - CNT_W'(1);
          leds_nxt = onehot(color_q);
`ifdef COLOR_DISPLAY_TONE_EN
          if (tone_cnt == tone_half_m1) begin
            tone_nxt     = ~tone_q;
            tone_cnt_nxt = '0;
          end else begin
            tone_nxt     = tone_q;
            tone_cnt_nxt = tone_cnt + TONE_W'(1);
          end
`endif
        end
      end
      GAP: begin
        leds_nxt = '0;
        if (cnt == '0) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        leds_nxt  = '0;
      end
    endcase
    // Abort wins over everything, including a pending completion pulse.
    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      leds_nxt  = '0;
      done_nxt  = 1'b0;
`ifdef COLOR_DISPLAY_TONE_EN
      tone_nxt     = 1'b0;
      tone_cnt_nxt = '0;
`endif
    end
  end

endmodule

// File: tb/tb_color_sequence_display.sv
// Bench for color_sequence_display with ON_CYCLES=4, OFF_CYCLES=2: per-cycle vector table plus a handshake-spacing sequence.
module tb_color_sequence_display;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] color_in = 2'b00;
  logic       color_valid = 1'b0;
  logic       flush = 1'b0;
  logic       color_ready, led_green, led_red, led_blue, led_yellow, busy, show_done;
`ifdef COLOR_DISPLAY_TONE_EN
  logic       tone_out;
`endif

  color_sequence_display #(.ON_CYCLES(4), .OFF_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .color_in(color_in), .color_valid(color_valid),
    .color_ready(color_ready), .flush(flush),
    .led_green(led_green), .led_red(led_red), .led_blue(led_blue), .led_yellow(led_yellow),
    .busy(busy), .show_done(show_done)
`ifdef COLOR_DISPLAY_TONE_EN
    , .tone_out(tone_out)
`endif
  );

  always #5 clk = ~clk;

  // exp = {ready, leds{y,b,r,g}, busy, show_done}
  typedef struct packed {
    logic       rst;
    logic       valid;
    logic [1:0] color;
    logic       fl;
    logic [6:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [6:0]  exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic add(input int n, input logic r, input logic v, input logic [1:0] c, input logic f,
                     input logic rdy, input logic [3:0] leds, input logic bsy, input logic dn);
    vec_t e;
    e.rst = r; e.valid = v; e.color = c; e.fl = f; e.exp = {rdy, leds, bsy, dn};
    for (int k = 0; k < n; k++) vecs.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  initial begin
    logic [6:0] act, e;
    int hs_cnt, hs_first, hs_second, done_cnt;

    add(1, 0,0,0,0, 1,4'b0000,0,0);     // in reset
    add(1, 1,0,0,0, 1,4'b0000,0,0);
    add(1, 1,1,2,0, 1,4'b0000,0,0);     // blue accepted
    add(4, 1,0,0,0, 0,4'b0100,1,0);
    add(2, 1,0,0,0, 0,4'b0000,1,0);
    add(1, 1,0,0,0, 1,4'b0000,0,1);
    add(1, 1,0,0,0, 1,4'b0000,0,0);
    add(1, 1,1,0,0, 1,4'b0000,0,0);     // green accepted, valid held
    add(4, 1,1,3,0, 0,4'b0001,1,0);     // color_in changes but is ignored
    add(2, 1,1,3,0, 0,4'b0000,1,0);
    add(1, 1,1,3,0, 1,4'b0000,0,1);     // yellow accepted in done cycle
    add(4, 1,0,0,0, 0,4'b1000,1,0);
    add(2, 1,0,0,0, 0,4'b0000,1,0);
    add(1, 1,0,0,0, 1,4'b0000,0,1);
    add(1, 1,0,0,0, 1,4'b0000,0,0);
    add(1, 1,1,1,0, 1,4'b0000,0,0);     // red accepted
    add(1, 1,0,0,0, 0,4'b0010,1,0);
    add(1, 1,0,0,1, 0,4'b0010,1,0);     // flush in 2nd ON cycle
    add(5, 1,0,0,0, 1,4'b0000,0,0);
    add(1, 1,1,2,1, 0,4'b0000,0,0);     // flush beats valid
    add(1, 1,0,0,0, 1,4'b0000,0,0);
    add(1, 1,1,3,0, 1,4'b0000,0,0);     // yellow accepted
    add(4, 1,0,0,0, 0,4'b1000,1,0);
    add(1, 1,0,0,0, 0,4'b0000,1,0);
    add(1, 0,0,0,0, 1,4'b0000,0,0);     // reset during gap
    add(4, 1,0,0,0, 1,4'b0000,0,0);
    add(1, 1,1,0,0, 1,4'b0000,0,0);     // green accepted
    add(4, 1,0,0,0, 0,4'b0001,1,0);
    add(1, 1,0,0,0, 0,4'b0000,1,0);
    add(1, 1,0,0,1, 0,4'b0000,1,0);     // flush in last gap cycle
    add(2, 1,0,0,0, 1,4'b0000,0,0);

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      rst_n = vecs[i].rst; color_valid = vecs[i].valid;
      color_in = vecs[i].color; flush = vecs[i].fl;
      exp_q.push_back(vecs[i].exp);
      @(negedge clk);
      act = {color_ready, led_yellow, led_blue, led_red, led_green, busy, show_done};
      e = exp_q.pop_front();
      check($sformatf("vec%0d", i), int'(act), int'(e));
    end

    // Two colours with valid held: handshake spacing and completion count.
    hs_cnt = 0; hs_first = 0; hs_second = 0; done_cnt = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk); #1;
      color_valid = (hs_cnt < 2);
      color_in    = (hs_cnt == 0) ? 2'b00 : 2'b11;
      @(negedge clk);
      if (color_valid && color_ready) begin
        if (hs_cnt == 0) hs_first = cyc; else hs_second = cyc;
        hs_cnt++;
      end
      if (show_done) done_cnt++;
    end
    check("handshake_count", hs_cnt, 2);
    check("handshake_spacing", hs_second - hs_first, 7);
    check("show_done_count", done_cnt, 2);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
